// File: rtl/sram_loader_arb_pkg.sv
// Shared definitions for the SRAM loader arbiter: ZX-Uno register map,
// sequencer state encoding, access length default and address helpers.
package sram_loader_arb_pkg;

    localparam logic [7:0] DEF_ADDR_LDCTRL = 8'hE0;
    localparam logic [7:0] DEF_ADDR_LDADDR = 8'hE1;
    localparam logic [7:0] DEF_ADDR_LDDATA = 8'hE2;
    localparam int         DEF_ACC_CYCLES  = 2;
    localparam int         LD_AW           = 20;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAITBUS = 2'd1;
    localparam logic [1:0] ST_ACCESS  = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    typedef logic [LD_AW-1:0] ld_addr_t;

    typedef enum logic [1:0] {
        PTR_B0 = 2'd0,
        PTR_B1 = 2'd1,
        PTR_B2 = 2'd2
    } addr_ptr_e;

    // LDADDR byte pointer walks 0 -> 1 -> 2 -> 0
    function automatic addr_ptr_e next_ptr(input addr_ptr_e p);
        case (p)
            PTR_B0:  return PTR_B1;
            PTR_B1:  return PTR_B2;
            PTR_B2:  return PTR_B0;
            default: return PTR_B0;
        endcase
    endfunction

    // 20-bit address step; 0xFFFFF rolls over to 0x00000
    function automatic ld_addr_t addr_inc(input ld_addr_t a);
        return a + 20'd1;
    endfunction

    // LDCTRL read image
    function automatic logic [7:0] ctrl_status(input logic en, input logic busy);
        return {en, 6'b000000, busy};
    endfunction

endpackage

// File: rtl/sram_loader_arb_if.sv
// Bus bundle of the SRAM loader: ZX-Uno register strobes plus the loader's
// side of the SRAM pin multiplexer. master = loader, slave = system side.
interface sram_loader_arb_if;
    import sram_loader_arb_pkg::*;

    logic [7:0]       zxuno_addr;
    logic             zxuno_regrd;
    logic             zxuno_regwr;
    logic             cpu_sram_busy;
    logic [7:0]       sram_din;
    logic             ld_grant;
    logic [LD_AW-1:0] ld_sram_addr;
    logic [7:0]       ld_sram_dout;
    logic             ld_sram_oe_n;
    logic             ld_sram_we_n;

    modport master (
        input  zxuno_addr, zxuno_regrd, zxuno_regwr, cpu_sram_busy, sram_din,
        output ld_grant, ld_sram_addr, ld_sram_dout, ld_sram_oe_n, ld_sram_we_n
    );

    modport slave (
        output zxuno_addr, zxuno_regrd, zxuno_regwr, cpu_sram_busy, sram_din,
        input  ld_grant, ld_sram_addr, ld_sram_dout, ld_sram_oe_n, ld_sram_we_n
    );

endinterface

// File: rtl/sram_loader_arb_zxuno_regstrobe.sv
// zxuno_regstrobe: turns a (possibly multi-clk) register strobe aimed at
// REG_ADDR into a single-clk action pulse on the first matching clk.
module zxuno_regstrobe #(
    parameter logic [7:0] REG_ADDR = 8'h00
) (
    input  logic       clk,
    input  logic       mrst,
    input  logic [7:0] zxuno_addr,
    input  logic       strobe,
    output logic       pulse
);

    logic hit_s;
    logic hit_prev_r;

    assign hit_s = strobe && (zxuno_addr == REG_ADDR);
    assign pulse = hit_s && !hit_prev_r;

    // remember last clk's hit so a held strobe fires only once
    always_ff @(posedge clk) begin
        if (mrst) begin
            hit_prev_r <= 1'b0;
        end else begin
            hit_prev_r <= hit_s;
        end
    end

endmodule

// File: rtl/sram_loader_arb.sv
// sram_loader_arb: ZX-Uno register-driven SRAM loader that borrows the SRAM
// pins whenever the CPU is not using them; the CPU always wins a collision.
// Optional feature macro: LOADER_READBACK_EN (prefetching read path through
// LDDATA reads). Without it the loader only ever writes.
module sram_loader_arb
    import sram_loader_arb_pkg::*;
#(
    parameter logic [7:0] ADDR_LDCTRL = DEF_ADDR_LDCTRL,
    parameter logic [7:0] ADDR_LDADDR = DEF_ADDR_LDADDR,
    parameter logic [7:0] ADDR_LDDATA = DEF_ADDR_LDDATA,
    parameter int         ACC_CYCLES  = DEF_ACC_CYCLES
) (
    input  logic              clk,
    input  logic              mrst,
    sram_loader_arb_if.master bus,
    inout  wire  [7:0]        d
);

    localparam logic [7:0] ACC_LAST = 8'(ACC_CYCLES - 1);

    logic       ctrl_wr_s;
    logic       addr_wr_s;
    logic       data_wr_s;
    logic       busy_s;
    logic       wr_req_s;
    logic       rd_req_s;
    logic       req_any_s;
    logic       d_oe_s;
    logic [7:0] d_out_s;

    logic       enable_r;
    addr_ptr_e  ptr_r;
    logic [7:0] dout_r;
    logic [1:0] state_r;
    logic [7:0] cnt_r;
    logic       grant_r;
    logic       we_n_r;
    logic       oe_n_r;
    logic       is_read_r;
    ld_addr_t   addr_r;

    zxuno_regstrobe #(.REG_ADDR(ADDR_LDCTRL)) u_ctrl_wr (
        .clk(clk), .mrst(mrst), .zxuno_addr(bus.zxuno_addr),
        .strobe(bus.zxuno_regwr), .pulse(ctrl_wr_s)
    );

    zxuno_regstrobe #(.REG_ADDR(ADDR_LDADDR)) u_addr_wr (
        .clk(clk), .mrst(mrst), .zxuno_addr(bus.zxuno_addr),
        .strobe(bus.zxuno_regwr), .pulse(addr_wr_s)
    );

    zxuno_regstrobe #(.REG_ADDR(ADDR_LDDATA)) u_data_wr (
        .clk(clk), .mrst(mrst), .zxuno_addr(bus.zxuno_addr),
        .strobe(bus.zxuno_regwr), .pulse(data_wr_s)
    );

    assign busy_s    = (state_r != ST_IDLE);
    assign wr_req_s  = data_wr_s && enable_r && !busy_s;
    assign req_any_s = wr_req_s || rd_req_s;

`ifdef LOADER_READBACK_EN
    logic       data_rd_s;
    logic [7:0] prefetch_r;

    zxuno_regstrobe #(.REG_ADDR(ADDR_LDDATA)) u_data_rd (
        .clk(clk), .mrst(mrst), .zxuno_addr(bus.zxuno_addr),
        .strobe(bus.zxuno_regrd), .pulse(data_rd_s)
    );

    // a prefetch is queued by the last LDADDR byte or by consuming LDDATA
    assign rd_req_s = enable_r && !busy_s &&
                      (data_rd_s || (addr_wr_s && (ptr_r == PTR_B2)));

    // capture SRAM data on the final clk of an uninterrupted read access
    always_ff @(posedge clk) begin
        if (mrst) begin
            prefetch_r <= 8'h00;
        end else if ((state_r == ST_ACCESS) && (cnt_r == ACC_LAST) &&
                     is_read_r && !bus.cpu_sram_busy) begin
            prefetch_r <= bus.sram_din;
        end
    end
`else
    assign rd_req_s = 1'b0;
`endif

    // enable bit, LDADDR byte pointer and write-data latch
    always_ff @(posedge clk) begin
        if (mrst) begin
            enable_r <= 1'b0;
            ptr_r    <= PTR_B0;
            dout_r   <= 8'h00;
        end else begin
            if (ctrl_wr_s) begin
                enable_r <= d[7];
                ptr_r    <= PTR_B0;
            end else if (addr_wr_s && !busy_s) begin
                ptr_r <= next_ptr(ptr_r);
            end
            if (wr_req_s) begin
                dout_r <= d;
            end
        end
    end

    // sequencer: request pickup, wait for a free bus, timed access, release
    always_ff @(posedge clk) begin
        if (mrst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 8'd0;
            grant_r   <= 1'b0;
            we_n_r    <= 1'b1;
            oe_n_r    <= 1'b1;
            is_read_r <= 1'b0;
            addr_r    <= 20'h00000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // address bytes are only accepted while nothing is in flight
                    if (addr_wr_s) begin
                        case (ptr_r)
                            PTR_B0:  addr_r[7:0]   <= d;
                            PTR_B1:  addr_r[15:8]  <= d;
                            PTR_B2:  addr_r[19:16] <= d[3:0];
                            default: addr_r        <= addr_r;
                        endcase
                    end
                    if (req_any_s) begin
                        state_r   <= ST_WAITBUS;
                        is_read_r <= rd_req_s;
                    end
                end
                ST_WAITBUS: begin
                    if (!enable_r) begin
                        state_r <= ST_IDLE;
                    end else if (!bus.cpu_sram_busy) begin
                        state_r <= ST_ACCESS;
                        cnt_r   <= 8'd0;
                        grant_r <= 1'b1;
                        we_n_r  <= is_read_r;
                        oe_n_r  <= !is_read_r;
                    end
                end
                ST_ACCESS: begin
                    if (bus.cpu_sram_busy) begin
                        // CPU collision: back off and redo the whole access later
                        state_r <= ST_WAITBUS;
                        cnt_r   <= 8'd0;
                        grant_r <= 1'b0;
                        we_n_r  <= 1'b1;
                        oe_n_r  <= 1'b1;
                    end else if (cnt_r == ACC_LAST) begin
                        state_r <= ST_RELEASE;
                        we_n_r  <= 1'b1;
                        oe_n_r  <= 1'b1;
                    end else begin
                        // write strobe rises one clk early so data holds past we_n
                        cnt_r  <= cnt_r + 8'd1;
                        we_n_r <= is_read_r || !((cnt_r + 8'd1) < ACC_LAST);
                    end
                end
                ST_RELEASE: begin
                    state_r <= ST_IDLE;
                    grant_r <= 1'b0;
                    addr_r  <= addr_inc(addr_r);
                end
                default: begin
                    state_r <= ST_IDLE;
                    grant_r <= 1'b0;
                    we_n_r  <= 1'b1;
                    oe_n_r  <= 1'b1;
                end
            endcase
        end
    end

    // CPU read mux: only our own readable registers drive the data bus
    always_comb begin
        d_oe_s  = 1'b0;
        d_out_s = 8'h00;
        if (bus.zxuno_regrd && (bus.zxuno_addr == ADDR_LDCTRL)) begin
            d_oe_s  = 1'b1;
            d_out_s = ctrl_status(enable_r, busy_s);
        end
`ifdef LOADER_READBACK_EN
        else if (bus.zxuno_regrd && (bus.zxuno_addr == ADDR_LDDATA)) begin
            d_oe_s  = 1'b1;
            d_out_s = prefetch_r;
        end
`endif
        else begin
            d_oe_s  = 1'b0;
            d_out_s = 8'h00;
        end
    end

    assign d = d_oe_s ? d_out_s : 8'hzz;

    assign bus.ld_grant     = grant_r;
    assign bus.ld_sram_addr = addr_r;
    assign bus.ld_sram_dout = dout_r;
    assign bus.ld_sram_oe_n = oe_n_r;
    assign bus.ld_sram_we_n = we_n_r;

endmodule

// File: doc/sram_loader_arb.md
SRAM_LOADER_ARB -- requirements
Module: sram_loader_arb

Interface
REQ-001 Parameters: ADDR_LDCTRL 8'hE0, control/status register; ADDR_LDADDR 8'hE1, address register; ADDR_LDDATA 8'hE2, data port; ACC_CYCLES 2, SRAM access length in clk cycles (SHALL be >=2).
REQ-002 Ports:
- clk  in  1  system clock.
- mrst  in  1  reset; one clock, reset synchronous and active-high.
- zxuno_addr  in  8  selected ZX-Uno register.
- zxuno_regrd  in  1  register read strobe.
- zxuno_regwr  in  1  register write strobe.
- d  inout  8  CPU data bus; driven only during own-register reads, else high-Z.
- cpu_sram_busy  in  1  CPU-side SRAM access in progress (modo sram_oe_n or sram_write_n low).
- sram_din  in  8  SRAM data read back.
- ld_grant  out  1  SRAM pin mux select to loader.
- ld_sram_addr  out  20  loader SRAM address.
- ld_sram_dout  out  8  loader write data.
- ld_sram_oe_n  out  1  loader read enable.
- ld_sram_we_n  out  1  loader write enable.

Function
REQ-003 Register actions SHALL fire once per strobe: first clk where strobe=1 and zxuno_addr matches; held strobes do not repeat.
REQ-004 LDCTRL write: bit7 -> enable; byte pointer reset to 0. LDCTRL read returns {enable,6'b0,busy}; busy=1 when state != IDLE.
REQ-005 LDADDR write: byte pointer 0/1/2 loads addr[7:0]/[15:8]/[19:16] (d[3:0]); pointer 2 wraps to 0. LDADDR not readable (d high-Z).
REQ-006 LDDATA write with enable=1 and busy=0: latch d into ld_sram_dout, queue write; with busy=1 or enable=0 the write SHALL be dropped, no state change.
REQ-007 FSM states: IDLE, WAITBUS, ACCESS, RELEASE; queued request moves IDLE->WAITBUS next clk.
REQ-008 WAITBUS->ACCESS on first clk with cpu_sram_busy=0; ld_grant=1 from the ACCESS entry clk until RELEASE exit.
REQ-009 ACCESS lasts ACC_CYCLES clks; write: ld_sram_we_n=0 for first ACC_CYCLES-1 clks, 1 on last; read: ld_sram_oe_n=0 all ACCESS clks, sram_din sampled on last clk.
REQ-010 RELEASE: one clk, grant=1, we_n=oe_n=1; then IDLE with addr incremented by 1, 20'hFFFFF wrapping to 0.
REQ-011 cpu_sram_busy=1 during ACCESS: CPU wins; abort, grant=0 and strobes high next clk, return to WAITBUS, retry full access, addr unchanged.
REQ-012 enable cleared in WAITBUS cancels request to IDLE; cleared in ACCESS/RELEASE, access completes.
REQ-013 LDADDR write while busy SHALL be ignored.

Reset
REQ-014 mrst=1 at clk edge: enable 0, pointer 0, addr 0, dout 0, prefetch 0, state IDLE; ld_grant 0, ld_sram_oe_n 1, ld_sram_we_n 1 from next clk, including mid-access (access abandoned, addr not incremented).

Configuration
REQ-015 Macro LOADER_READBACK_EN: defined -> third LDADDR write (pointer 2) queues prefetch read; LDDATA read returns prefetch register and queues next prefetch; if busy, read returns stale prefetch register, no new request. Undefined -> no read accesses, ld_sram_oe_n constant 1, LDDATA reads leave d high-Z.

Structure
REQ-016 Shared package: register address constants, FSM state encoding, ACC_CYCLES default, 20-bit address width.
REQ-017 One sub-module, zxuno_regstrobe: per-register single-clk action pulse generator (REQ-003), instanced per register/direction.

Verification
REQ-018 LDADDR writes 34,12,05; LDDATA write AA, cpu_sram_busy=0 -> ld_grant 1 for 3 clks, we_n low 1 clk at addr 0x51234, then addr 0x51235.
REQ-019 cpu_sram_busy=1 during WAITBUS for 10 clks -> ld_grant 0 throughout; access starts clk after busy falls.
REQ-020 cpu_sram_busy rises on ACCESS clk 1 -> grant drops next clk, retry at same addr, single increment at completion.
REQ-021 addr FF,FF,0F, write 55 -> write at 0xFFFFF, addr becomes 0x00000; second LDDATA write while busy dropped.
REQ-022 LOADER_READBACK_EN, SRAM[0x00100]=3C, [0x00101]=C3: LDADDR 00,01,00, two LDDATA reads -> d=3C then C3.
REQ-023 mrst mid-ACCESS -> next clk grant 0, we_n 1, LDCTRL reads 00.
